// File: rtl/mem_stage_oq.sv
// Memory-access pipeline stage between EX and WB: tracks outstanding data-SRAM responses,
// buffers load data across WB stalls and drops responses that belong to flushed requests.
module mem_stage_oq #(
    parameter int DW        = 32,
    parameter int EX_W      = 86,
    parameter int MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            es_to_ms_valid,
    output logic            ms_allowin,
    input  logic            ws_allowin,
    output logic            ms_to_ws_valid,
    input  logic [DW-1:0]   es_pc,
    input  logic [DW-1:0]   es_result,
    input  logic            es_res_from_mem,
    input  logic            es_mem_req,
    input  logic [4:0]      es_ld_op,
    input  logic            es_rf_we,
    input  logic [4:0]      es_rf_waddr,
    input  logic            es_csr_re,
    input  logic [EX_W-1:0] es_ex_zip,
    input  logic            es_req_pending,
    input  logic            data_sram_data_ok,
    input  logic [DW-1:0]   data_sram_rdata,
    input  logic            wb_ex,
    output logic [DW-1:0]   ms_pc,
    output logic [DW-1:0]   ms_result,
    output logic            ms_rf_we,
    output logic [4:0]      ms_rf_waddr,
    output logic [DW-1:0]   ms_rf_wdata,
    output logic            ms_fwd_ok,
    output logic            ms_ex,
    output logic [EX_W-1:0] ms_ex_zip,
    output logic            ms_csr_re
);
    localparam int CW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   discard_cnt_q, discard_cnt_d;
    logic [DW-1:0]   rdata_buf_q;
    logic [DW-1:0]   pc_q, result_q;
    logic            res_from_mem_q, rf_we_q, csr_re_q;
    logic [4:0]      ld_op_q, rf_waddr_q;
    logic [EX_W-1:0] ex_zip_q;

    logic          ms_valid, discard_nz, drop_data, use_data, ready_go, accept, wait_inc;
    logic [DW-1:0] ld_rdata, ld_ext;
    logic [15:0]   ld_sh;

    assign ms_valid   = (state_q != S_IDLE);
    assign discard_nz = |discard_cnt_q;
    // A pending discard always claims data_ok first: responses come back in request order.
    assign drop_data  = data_sram_data_ok & discard_nz;
    assign use_data   = data_sram_data_ok & ~discard_nz & (state_q == S_WAIT);
    assign ready_go   = (state_q == S_DONE) | use_data;
    assign wait_inc   = (state_q == S_WAIT) & ~use_data;

    assign ms_to_ws_valid = ms_valid & ready_go & ~wb_ex;
    assign ms_allowin     = ~ms_valid | (ready_go & ws_allowin);
    assign accept         = es_to_ms_valid & ms_allowin & ~wb_ex;

    always_comb begin
        state_d       = state_q;
        discard_cnt_d = discard_cnt_q - CW'(drop_data);
        if (wb_ex) begin
            state_d       = S_IDLE;
            discard_cnt_d = discard_cnt_q + CW'(wait_inc) + CW'(es_req_pending) - CW'(drop_data);
        end else if (ms_allowin) begin
            if (es_to_ms_valid) begin
                state_d = es_mem_req ? S_WAIT : S_DONE;
            end else begin
                state_d = S_IDLE;
            end
        end else if (use_data) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            discard_cnt_q  <= '0;
            rdata_buf_q    <= '0;
            pc_q           <= '0;
            result_q       <= '0;
            res_from_mem_q <= 1'b0;
            ld_op_q        <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            csr_re_q       <= 1'b0;
            ex_zip_q       <= '0;
        end else begin
            state_q       <= state_d;
            discard_cnt_q <= discard_cnt_d;
            if (use_data) begin
                rdata_buf_q <= data_sram_rdata;
            end
            if (accept) begin
                pc_q           <= es_pc;
                result_q       <= es_result;
                res_from_mem_q <= es_res_from_mem;
                ld_op_q        <= es_ld_op;
                rf_we_q        <= es_rf_we;
                rf_waddr_q     <= es_rf_waddr;
                csr_re_q       <= es_csr_re;
                ex_zip_q       <= es_ex_zip;
            end
        end
    end

    // Capture cycle bypasses the bus data straight through; later cycles read the buffer.
    always_comb begin
        ld_rdata = use_data ? data_sram_rdata : rdata_buf_q;
        ld_sh    = 16'(ld_rdata >> {result_q[1:0], 3'b000});
        if (ld_op_q[0]) begin
            ld_ext = ld_rdata;
        end else if (ld_op_q[4]) begin
            ld_ext = {{(DW-8){ld_sh[7]}}, ld_sh[7:0]};
        end else if (ld_op_q[3]) begin
            ld_ext = {{(DW-8){1'b0}}, ld_sh[7:0]};
        end else if (ld_op_q[2]) begin
            ld_ext = {{(DW-16){ld_sh[15]}}, ld_sh};
        end else if (ld_op_q[1]) begin
            ld_ext = {{(DW-16){1'b0}}, ld_sh};
        end else begin
            ld_ext = ld_rdata;
        end
    end

    assign ms_pc       = pc_q;
    assign ms_result   = result_q;
    assign ms_rf_we    = rf_we_q & ms_valid;
    assign ms_rf_waddr = rf_waddr_q;
    assign ms_rf_wdata = res_from_mem_q ? ld_ext : result_q;
    assign ms_fwd_ok   = ms_valid & rf_we_q & ~csr_re_q & (~res_from_mem_q | ready_go);
    assign ms_ex       = (|ex_zip_q[6:0]) & ms_valid;
    assign ms_ex_zip   = ex_zip_q;
    assign ms_csr_re   = csr_re_q;

endmodule

// File: tb/tb_mem_stage_oq.sv
// Directed bench for mem_stage_oq: scoreboard of expected WB hand-offs plus per-step checks.
module tb_mem_stage_oq;
    localparam int DW = 32;
    localparam int EX_W = 86;
    localparam int MAX_OUTST = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic            es_to_ms_valid, ms_allowin, ws_allowin, ms_to_ws_valid;
    logic [DW-1:0]   es_pc, es_result;
    logic            es_res_from_mem, es_mem_req;
    logic [4:0]      es_ld_op;
    logic            es_rf_we;
    logic [4:0]      es_rf_waddr;
    logic            es_csr_re;
    logic [EX_W-1:0] es_ex_zip;
    logic            es_req_pending, data_sram_data_ok;
    logic [DW-1:0]   data_sram_rdata;
    logic            wb_ex;
    logic [DW-1:0]   ms_pc, ms_result;
    logic            ms_rf_we;
    logic [4:0]      ms_rf_waddr;
    logic [DW-1:0]   ms_rf_wdata;
    logic            ms_fwd_ok, ms_ex;
    logic [EX_W-1:0] ms_ex_zip;
    logic            ms_csr_re;

    mem_stage_oq #(.DW(DW), .EX_W(EX_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .resetn(resetn),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .es_pc(es_pc), .es_result(es_result), .es_res_from_mem(es_res_from_mem),
        .es_mem_req(es_mem_req), .es_ld_op(es_ld_op), .es_rf_we(es_rf_we),
        .es_rf_waddr(es_rf_waddr), .es_csr_re(es_csr_re), .es_ex_zip(es_ex_zip),
        .es_req_pending(es_req_pending), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .wb_ex(wb_ex),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_rf_we(ms_rf_we),
        .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata), .ms_fwd_ok(ms_fwd_ok),
        .ms_ex(ms_ex), .ms_ex_zip(ms_ex_zip), .ms_csr_re(ms_csr_re)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    localparam logic [4:0] OP_B  = 5'b10000;
    localparam logic [4:0] OP_BU = 5'b01000;
    localparam logic [4:0] OP_H  = 5'b00100;
    localparam logic [4:0] OP_W  = 5'b00001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Per-cycle monitor, then advance to just after the next rising edge.
    task automatic next();
        exp_t e;
        logic [1:0] st;
        #1;
        st = dut.state_q;
        chk("discard_bound", 32'(dut.discard_cnt_q <= MAX_OUTST), 32'd1);
        chk("spurious_data_ok",
            32'(data_sram_data_ok && dut.discard_cnt_q == 0 && st != 2'd1), 32'd0);
        if (ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                chk("unexpected_handoff", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("handoff_pc", ms_pc, e.pc);
                chk("handoff_wdata", ms_rf_wdata, e.wdata);
                $display("handoff pc=%08h wdata=%08h", ms_pc, ms_rf_wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic rfm,
                        input logic memreq, input logic [4:0] op, input logic we,
                        input logic csr, input logic [6:0] flags, input logic push,
                        input logic [31:0] exp_wdata);
        es_pc = pc; es_result = res; es_res_from_mem = rfm; es_mem_req = memreq;
        es_ld_op = op; es_rf_we = we; es_rf_waddr = 5'd4; es_csr_re = csr;
        es_ex_zip = '0; es_ex_zip[6:0] = flags;
        es_to_ms_valid = 1'b1;
        settle();
        chk("send_allowin", 32'(ms_allowin), 32'd1);
        if (push) sb.push_back('{pc: pc, wdata: exp_wdata});
        next();
        es_to_ms_valid = 1'b0;
    endtask

    // Load with a response after `gap` idle cycles, completing in the data_ok cycle.
    task automatic load_resp(input logic [31:0] pc, input logic [31:0] addr, input logic [4:0] op,
                             input logic [31:0] rdata, input logic [31:0] exp_wdata,
                             input int gap);
        send(pc, addr, 1'b1, 1'b1, op, 1'b1, 1'b0, 7'd0, 1'b1, exp_wdata);
        for (int i = 0; i < gap; i++) begin
            settle();
            chk("wait_valid", 32'(ms_to_ws_valid), 32'd0);
            chk("wait_fwd_ok", 32'(ms_fwd_ok), 32'd0);
            next();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = rdata;
        settle();
        chk("resp_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("resp_wdata", ms_rf_wdata, exp_wdata);
        chk("resp_fwd_ok", 32'(ms_fwd_ok), 32'd1);
        next();
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
        es_pc = '0; es_result = '0; es_res_from_mem = 1'b0; es_mem_req = 1'b0;
        es_ld_op = '0; es_rf_we = 1'b0; es_rf_waddr = '0; es_csr_re = 1'b0; es_ex_zip = '0;
        es_req_pending = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_ex = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_fwd_ok", 32'(ms_fwd_ok), 32'd0);
        chk("rst_pc", ms_pc, 32'd0);
        chk("rst_wdata", ms_rf_wdata, 32'd0);
        resetn = 1'b1;
        next();

        // ld.w with response three cycles after entry.
        load_resp(32'h1c00_0000, 32'h0000_1000, OP_W, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2);
        // Byte/halfword selection and extension.
        load_resp(32'h1c00_0004, 32'h0000_2003, OP_B,  32'h80FF_0000, 32'hFFFF_FF80, 0);
        load_resp(32'h1c00_0008, 32'h0000_2003, OP_BU, 32'h80FF_0000, 32'h0000_0080, 0);
        load_resp(32'h1c00_000c, 32'h0000_2002, OP_H,  32'h80FF_0000, 32'hFFFF_80FF, 0);

        // ALU result passes straight through and is forwardable at once.
        send(32'h1c00_0010, 32'hCAFE_0001, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 7'd0, 1'b1, 32'hCAFE_0001);
        settle();
        chk("alu_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("alu_wdata", ms_rf_wdata, 32'hCAFE_0001);
        chk("alu_fwd_ok", 32'(ms_fwd_ok), 32'd1);
        next();

        // Response arrives while WB stalls for 4 cycles; buffered data must persist.
        send(32'h1c00_0014, 32'h0000_3000, 1'b1, 1'b1, OP_W, 1'b1, 1'b0, 7'd0, 1'b1, 32'h1234_5678);
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
        settle();
        chk("stall_capture_valid", 32'(ms_to_ws_valid), 32'd1);
        next();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stall_valid", 32'(ms_to_ws_valid), 32'd1);
            chk("stall_wdata", ms_rf_wdata, 32'h1234_5678);
            chk("stall_allowin", 32'(ms_allowin), 32'd0);
            next();
        end
        ws_allowin = 1'b1;
        next();

        // Flush in WAIT with a request pending in ES: two responses must be dropped.
        send(32'h1c00_0018, 32'h0000_4000, 1'b1, 1'b1, OP_W, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0);
        wb_ex = 1'b1; es_req_pending = 1'b1;
        settle();
        chk("flush_valid", 32'(ms_to_ws_valid), 32'd0);
        next();
        wb_ex = 1'b0; es_req_pending = 1'b0;
        settle();
        chk("flush_discard_cnt", 32'(dut.discard_cnt_q), 32'd2);
        send(32'h1c00_001c, 32'h0000_5000, 1'b1, 1'b1, OP_W, 1'b1, 1'b0, 7'd0, 1'b1, 32'h0000_0033);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0011;
        settle();
        chk("drop1_valid", 32'(ms_to_ws_valid), 32'd0);
        next();
        data_sram_rdata = 32'h0000_0022;
        settle();
        chk("drop2_valid", 32'(ms_to_ws_valid), 32'd0);
        next();
        data_sram_rdata = 32'h0000_0033;
        settle();
        chk("drain_valid", 32'(ms_to_ws_valid), 32'd1);
        chk("drain_wdata", ms_rf_wdata, 32'h0000_0033);
        next();
        data_sram_data_ok = 1'b0;
        settle();
        chk("drain_discard_cnt", 32'(dut.discard_cnt_q), 32'd0);

        // Flush coinciding with the response: nothing to discard, nothing to WB.
        send(32'h1c00_0020, 32'h0000_6000, 1'b1, 1'b1, OP_W, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0);
        wb_ex = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0055;
        settle();
        chk("flush_ok_valid", 32'(ms_to_ws_valid), 32'd0);
        next();
        wb_ex = 1'b0; data_sram_data_ok = 1'b0;
        settle();
        chk("flush_ok_discard_cnt", 32'(dut.discard_cnt_q), 32'd0);
        chk("flush_ok_allowin", 32'(ms_allowin), 32'd1);

        // Reset in WAIT with one discard pending.
        send(32'h1c00_0024, 32'h0000_7000, 1'b1, 1'b1, OP_W, 1'b1, 1'b0, 7'd0, 1'b0, 32'd0);
        wb_ex = 1'b1;
        next();
        wb_ex = 1'b0;
        send(32'h1c00_0028, 32'h0000_7004, 1'b1, 1'b1, OP_W, 1'b1, 1'b1, 7'h04, 1'b0, 32'd0);
        settle();
        chk("pre_rst_discard_cnt", 32'(dut.discard_cnt_q), 32'd1);
        chk("pre_rst_ms_ex", 32'(ms_ex), 32'd1);
        chk("pre_rst_rf_we", 32'(ms_rf_we), 32'd1);
        chk("pre_rst_csr_re", 32'(ms_csr_re), 32'd1);
        resetn = 1'b0;
        next();
        settle();
        chk("mid_rst_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("mid_rst_allowin", 32'(ms_allowin), 32'd1);
        chk("mid_rst_fwd_ok", 32'(ms_fwd_ok), 32'd0);
        chk("mid_rst_pc", ms_pc, 32'd0);
        chk("mid_rst_result", ms_result, 32'd0);
        chk("mid_rst_wdata", ms_rf_wdata, 32'd0);
        chk("mid_rst_rf_we", 32'(ms_rf_we), 32'd0);
        chk("mid_rst_waddr", 32'(ms_rf_waddr), 32'd0);
        chk("mid_rst_ms_ex", 32'(ms_ex), 32'd0);
        chk("mid_rst_ex_zip", 32'(|ms_ex_zip), 32'd0);
        chk("mid_rst_csr_re", 32'(ms_csr_re), 32'd0);
        chk("mid_rst_discard_cnt", 32'(dut.discard_cnt_q), 32'd0);
        resetn = 1'b1;
        next();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
